d_sram_like_to_axi: RTL and testbench
=====================================

Name:
d_sram_like_to_axi

Overview:
- Data-side bridge directly downstream of the core's data sram-like port.
- Accepts one sram-like read or write at a time and forms the physical address from the TLB page frame.
- Issues a single-beat AXI3 read or write, then returns data_data_ok (plus read data) to the core.
- Constant AXI fields are driven by the top wrapper: id=1, len=0, burst=INCR, lock/cache/prot=0.

Parameters:
PAGE_BITS, 12, page-offset width; physical address = {data_pfn, data_addr[PAGE_BITS-1:0]}
PFN_W, 20, page frame number width; PFN_W+PAGE_BITS must equal 32

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
data_req  in  1  sram-like request
data_wr  in  1  1=write, 0=read
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  virtual address (only page offset used)
data_wdata  in  32  write data, already lane-aligned by core
data_pfn  in  PFN_W  physical frame from TLB, valid with data_req
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  transaction complete, one-cycle pulse
data_rdata  out  32  read data, valid when data_data_ok on a read
araddr  out  32  AXI read address
arsize  out  3  AXI read size
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  AXI read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  32  AXI write address
awsize  out  3  AXI write size
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  AXI write data
wstrb  out  4  byte strobes
wvalid  out  1  W valid (wlast tied 1 by wrapper)
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- Clock/reset: one clock (clk); rst synchronous, active-high.
- Reset: state=IDLE; all registers cleared; every valid/ready output and data_addr_ok/data_data_ok = 0; data_rdata = 0.
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B.
- IDLE:
  - data_addr_ok = data_req, combinational, same cycle.
  - On data_req, latch wr, size, paddr = {data_pfn, data_addr[11:0]}, wdata and wstrb.
  - Next state is RD_AR if wr=0, WR_REQ if wr=1.
  - data_addr_ok is 0 in every other state, so only one transaction is ever outstanding.
- RD_AR: arvalid=1, held stable until arready. On arready, go to RD_R.
- RD_R:
  - rready=1.
  - On rvalid: data_data_ok=1 and data_rdata=rdata, combinational this cycle; go to IDLE.
  - data_rdata holds its last value otherwise.
- WR_REQ:
  - awvalid and wvalid both raised on entry.
  - Each drops independently after its own handshake, tracked by aw_done/w_done flags; AW and W may complete in either order or the same cycle.
  - Go to WR_B when both are done.
- WR_B: bready=1. On bvalid: data_data_ok=1; go to IDLE. bresp is ignored.
- Request acceptance:
  - The earliest next acceptance is the cycle after data_data_ok; addr_ok and data_ok never assert in the same cycle.
  - Back-to-back transactions therefore have zero idle cycles beyond the FSM return.
- Address/size:
  - araddr/awaddr = latched paddr, unmodified; no realignment.
  - arsize/awsize = {1'b0, size}. size=3 is illegal and treated as word (size 2, wstrb=1111).
- wstrb:
  - byte: 0001 << paddr[1:0]
  - half: paddr[1] ? 1100 : 0011
  - word: 1111
- Read wstrb is don't-care; drive 0.
- Reset asserted mid-transaction: FSM returns to IDLE next edge and all valids drop. No data_data_ok is produced for the aborted request. Interconnect is reset by the same rst.
- data_req held high while the bridge is busy: ignored, no latch update.

Decomposition:
- Shared package: FSM state encoding, size codes (SZ_BYTE/HALF/WORD), AXI constants (ID=1, LEN=0, BURST_INCR=2'b01).
- One natural sub-module: wstrb_gen (size + addr[1:0] -> 4-bit strobe), combinational, reusable for the instruction side.

Test Plan:
1. Word read: req=1, wr=0, size=2, addr=0x0000_1A34, pfn=0x00ABC. Expect addr_ok same cycle, araddr=0x00AB_CA34, arsize=2. With arready after 2 cycles and rvalid with rdata=0xDEAD_BEEF: data_ok for 1 cycle, data_rdata=0xDEAD_BEEF.
2. Byte write: size=0, addr=0x...0003, wdata=0x7700_0000. Expect wstrb=1000, awsize=0. awready before wready, wready before awready, and both in the same cycle each give exactly one data_ok after bvalid.
3. Half write at addr[1]=1: expect wstrb=1100, awsize=1.
4. Busy back-pressure: second data_req held during an outstanding read. Expect addr_ok=0 until the cycle after data_ok, then accepted, with the second address taken from the inputs at that cycle.
5. Reset in RD_R with rvalid pending: rst=1 for 1 cycle. Expect all valids/readies=0, state IDLE, no data_ok. A following request completes normally.
6. Stalled slave: arready low for 10 cycles. Expect arvalid and araddr stable throughout, data_ok=0.

Source files
------------

// File: rtl/d_sram_like_to_axi_pkg.sv
// d_sram_like_to_axi_pkg: shared FSM encoding, size codes and AXI constants for the data-side bridge.
package d_sram_like_to_axi_pkg;
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_e;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] AXI_ID = 4'd1;
  localparam logic [3:0] AXI_LEN = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;
  // size code 3 is illegal on the sram-like side and is handled as a word
  function automatic logic [1:0] legal_size(input logic [1:0] s);
    return s == 2'd3 ? SZ_WORD : s;
  endfunction
endpackage

// File: rtl/d_sram_like_to_axi_wstrb_gen.sv
// d_sram_like_to_axi_wstrb_gen: byte-lane strobe from access size and low address bits.
module d_sram_like_to_axi_wstrb_gen
  import d_sram_like_to_axi_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_i,
  output logic [3:0] strb_o
);
  always_comb
    strb_o = size_i == SZ_BYTE ? 4'b0001 << addr_i :
             size_i == SZ_HALF ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/d_sram_like_to_axi.sv
// d_sram_like_to_axi: single-outstanding sram-like to single-beat AXI3 bridge for the data port.
module d_sram_like_to_axi
  import d_sram_like_to_axi_pkg::*;
#(
  parameter int PAGE_BITS = 12,
  parameter int PFN_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  input  logic [PFN_W-1:0] data_pfn,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,
  output logic [31:0]      araddr,
  output logic [2:0]       arsize,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      awaddr,
  output logic [2:0]       awsize,
  output logic             awvalid,
  input  logic             awready,
  output logic [31:0]      wdata,
  output logic [3:0]       wstrb,
  output logic             wvalid,
  input  logic             wready,
  input  logic             bvalid,
  output logic             bready
);
  state_e      state_q, state_d;
  logic [1:0]  size_q, size_in;
  logic [31:0] paddr_q, paddr_in, wdata_q, rdata_q;
  logic [3:0]  wstrb_q, strb_in;
  logic        aw_done_q, w_done_q, aw_fin, w_fin, accept, rd_done, unused_addr;

  assign size_in     = legal_size(data_size);
  assign paddr_in    = {data_pfn, data_addr[PAGE_BITS-1:0]};
  assign unused_addr = ^data_addr[31:PAGE_BITS];
  assign aw_fin      = aw_done_q | awready;
  assign w_fin       = w_done_q | wready;

  d_sram_like_to_axi_wstrb_gen u_wstrb_gen (
    .size_i (size_in),
    .addr_i (paddr_in[1:0]),
    .strb_o (strb_in)
  );

  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = data_req ? (data_wr ? WR_REQ : RD_AR) : IDLE;
      RD_AR:   state_d = arready ? RD_R : RD_AR;
      RD_R:    state_d = rvalid ? IDLE : RD_R;
      WR_REQ:  state_d = aw_fin && w_fin ? WR_B : WR_REQ;
      WR_B:    state_d = bvalid ? IDLE : WR_B;
      default: state_d = IDLE;
    endcase
  end

  // handshake outputs are forced low while rst is held so an aborted request never completes
  always_comb begin
    accept       = !rst && state_q == IDLE && data_req;
    rd_done      = !rst && state_q == RD_R && rvalid;
    data_addr_ok = accept;
    data_data_ok = rd_done || (!rst && state_q == WR_B && bvalid);
    data_rdata   = rd_done ? rdata : rdata_q;
    arvalid      = !rst && state_q == RD_AR;
    rready       = !rst && state_q == RD_R;
    awvalid      = !rst && state_q == WR_REQ && !aw_done_q;
    wvalid       = !rst && state_q == WR_REQ && !w_done_q;
    bready       = !rst && state_q == WR_B;
    araddr       = paddr_q;
    awaddr       = paddr_q;
    arsize       = {1'b0, size_q};
    awsize       = {1'b0, size_q};
    wdata        = wdata_q;
    wstrb        = wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q    <= 2'd0;
      paddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_q   <= 32'd0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (accept) begin
        size_q  <= size_in;
        paddr_q <= paddr_in;
        wdata_q <= data_wdata;
        wstrb_q <= data_wr ? strb_in : 4'd0;
      end
      if (rd_done) rdata_q <= rdata;
      aw_done_q <= state_q == WR_REQ && state_d == WR_REQ && aw_fin;
      w_done_q  <= state_q == WR_REQ && state_d == WR_REQ && w_fin;
    end
  end
endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// tb_d_sram_like_to_axi: table-driven and randomized transaction checks for the data-side bridge.
module tb_d_sram_like_to_axi;
  logic clk = 0, rst = 1;
  logic data_req = 0, data_wr = 0;
  logic [1:0] data_size = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic [19:0] data_pfn = 0;
  logic data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, araddr, awaddr, wdata;
  logic [2:0] arsize, awsize;
  logic arvalid, rready, awvalid, wvalid, bready;
  logic [3:0] wstrb;
  logic arready = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [31:0] rdata = 0;
  int n_chk = 0, n_pass = 0;

  typedef struct {
    logic wr; logic [1:0] size; logic [31:0] addr; logic [19:0] pfn;
    logic [31:0] wd, rd; int ar_d, aw_d, w_d, rsp_d;
    logic [31:0] paddr; logic [2:0] sz; logic [3:0] strb;
  } vec_t;
  vec_t tbl[10];

  d_sram_like_to_axi dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_pfn(data_pfn),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // reference: address from frame + page offset, strobe as a naturally aligned run of 2^size bytes
  function automatic vec_t model(input vec_t v);
    int eff, nb, off;
    eff = v.size == 2'd3 ? 2 : int'(v.size);
    nb = 1 << eff;
    off = int'(v.addr[1:0]) & (4 - nb);
    v.paddr = {v.pfn, v.addr[11:0]};
    v.sz = 3'(eff);
    v.strb = 4'(((1 << nb) - 1) << off);
    return v;
  endfunction

  task automatic txn(input vec_t v);
    int last;
    data_req = 1; data_wr = v.wr; data_size = v.size; data_addr = v.addr;
    data_pfn = v.pfn; data_wdata = v.wd;
    #1;
    chk("addr_ok", data_addr_ok, 1);
    chk("data_ok_idle", data_data_ok, 0);
    next_cycle;
    data_req = 0; data_addr = $urandom; data_pfn = 20'($urandom); data_wdata = $urandom;
    if (!v.wr) begin
      for (int c = 0; c <= v.ar_d; c++) begin
        arready = (c == v.ar_d);
        #1;
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, v.paddr);
        chk("arsize", arsize, v.sz);
        chk("wstrb_rd", wstrb, 0);
        chk("addr_ok_busy", data_addr_ok, 0);
        chk("data_ok_ar", data_data_ok, 0);
        next_cycle;
      end
      arready = 0;
      for (int c = 0; c <= v.rsp_d; c++) begin
        rvalid = (c == v.rsp_d);
        rdata = c == v.rsp_d ? v.rd : $urandom;
        #1;
        chk("arvalid_r", arvalid, 0);
        chk("rready", rready, 1);
        chk("data_ok_r", data_data_ok, 32'(c == v.rsp_d));
        if (c == v.rsp_d) chk("data_rdata", data_rdata, v.rd);
        next_cycle;
      end
      rvalid = 0; rdata = $urandom;
      #1;
      chk("rdata_hold", data_rdata, v.rd);
      chk("rready_idle", rready, 0);
    end else begin
      last = v.aw_d > v.w_d ? v.aw_d : v.w_d;
      for (int c = 0; c <= last; c++) begin
        awready = (c == v.aw_d);
        wready = (c == v.w_d);
        #1;
        chk("awvalid", awvalid, 32'(c <= v.aw_d));
        chk("wvalid", wvalid, 32'(c <= v.w_d));
        chk("awaddr", awaddr, v.paddr);
        chk("awsize", awsize, v.sz);
        chk("wstrb", wstrb, v.strb);
        chk("wdata", wdata, v.wd);
        chk("data_ok_w", data_data_ok, 0);
        next_cycle;
      end
      awready = 0; wready = 0;
      for (int c = 0; c <= v.rsp_d; c++) begin
        bvalid = (c == v.rsp_d);
        #1;
        chk("bready", bready, 1);
        chk("valids_b", {awvalid, wvalid}, 0);
        chk("data_ok_b", data_data_ok, 32'(c == v.rsp_d));
        next_cycle;
      end
      bvalid = 0;
      #1;
      chk("bready_idle", bready, 0);
    end
    chk("data_ok_once", data_data_ok, 0);
    chk("addr_ok_noreq", data_addr_ok, 0);
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{1'b0, 2'd2, 32'h0000_1A34, 20'h00ABC, 32'h0, 32'hDEAD_BEEF, 2, 0, 0, 0, 32'h00AB_CA34, 3'd2, 4'h0};
    tbl[1] = '{1'b1, 2'd0, 32'h0000_0003, 20'h12345, 32'h7700_0000, 32'h0, 0, 0, 1, 0, 32'h1234_5003, 3'd0, 4'h8};
    tbl[2] = '{1'b1, 2'd0, 32'h0000_0003, 20'h12345, 32'h7700_0000, 32'h0, 0, 1, 0, 1, 32'h1234_5003, 3'd0, 4'h8};
    tbl[3] = '{1'b1, 2'd0, 32'h0000_0003, 20'h12345, 32'h7700_0000, 32'h0, 0, 0, 0, 2, 32'h1234_5003, 3'd0, 4'h8};
    tbl[4] = '{1'b1, 2'd1, 32'h0000_0006, 20'h00001, 32'hBEEF_0000, 32'h0, 0, 2, 2, 0, 32'h0000_1006, 3'd1, 4'hC};
    tbl[5] = '{1'b1, 2'd1, 32'h0000_0ABC, 20'hFFFFF, 32'h0000_1234, 32'h0, 0, 3, 1, 1, 32'hFFFF_FABC, 3'd1, 4'h3};
    tbl[6] = '{1'b1, 2'd3, 32'h1234_5008, 20'h00042, 32'hCAFE_F00D, 32'h0, 0, 1, 1, 0, 32'h0004_2008, 3'd2, 4'hF};
    tbl[7] = '{1'b1, 2'd0, 32'hFFFF_F001, 20'h00002, 32'h0000_5500, 32'h0, 0, 0, 0, 0, 32'h0000_2001, 3'd0, 4'h2};
    tbl[8] = '{1'b0, 2'd0, 32'h0000_0002, 20'h80000, 32'h0, 32'h0000_5A00, 0, 0, 0, 1, 32'h8000_0002, 3'd0, 4'h0};
    tbl[9] = '{1'b0, 2'd2, 32'h0000_0FFC, 20'h00010, 32'h0, 32'h1234_5678, 10, 0, 0, 3, 32'h0001_0FFC, 3'd2, 4'h0};

    next_cycle; next_cycle;
    #1;
    chk("rst_outs", {arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 0);
    rst = 0;
    #1;
    chk("post_rst_outs", {arvalid, rready, awvalid, wvalid, bready, data_addr_ok, data_data_ok}, 0);
    chk("post_rst_rdata", data_rdata, 0);

    for (int i = 0; i < 10; i++) txn(tbl[i]);

    // busy back-pressure: a held request is ignored until the cycle after data_ok
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0100; data_pfn = 20'h11111;
    #1; chk("bp_accept1", data_addr_ok, 1);
    next_cycle;
    data_wr = 1; data_addr = 32'h0000_0204; data_pfn = 20'h22222; arready = 1;
    #1; chk("bp_busy_ar", data_addr_ok, 0); chk("bp_araddr", araddr, 32'h1111_1100);
    next_cycle;
    arready = 0;
    #1; chk("bp_busy_r", data_addr_ok, 0); chk("bp_araddr_r", araddr, 32'h1111_1100);
    next_cycle;
    rvalid = 1; rdata = 32'hA5A5_0001;
    #1; chk("bp_data_ok", data_data_ok, 1); chk("bp_no_overlap", data_addr_ok, 0);
    next_cycle;
    rvalid = 0; data_wr = 0; data_addr = 32'h0000_0308; data_pfn = 20'h33333;
    #1; chk("bp_accept2", data_addr_ok, 1);
    next_cycle;
    data_req = 0;
    #1; chk("bp_arvalid2", arvalid, 1); chk("bp_araddr2", araddr, 32'h3333_3308);
    arready = 1;
    next_cycle;
    arready = 0; rvalid = 1; rdata = 32'h0BAD_CAFE;
    #1; chk("bp_data_ok2", data_data_ok, 1); chk("bp_rdata2", data_rdata, 32'h0BAD_CAFE);
    next_cycle;
    rvalid = 0;

    // reset while in RD_R with rvalid pending aborts without completion
    data_req = 1; data_wr = 0; data_size = 2; data_addr = 32'h0000_0040; data_pfn = 20'h44444;
    next_cycle;
    data_req = 0; arready = 1;
    next_cycle;
    arready = 0; rvalid = 1; rdata = 32'h5555_AAAA; rst = 1;
    #1; chk("rst_no_data_ok", data_data_ok, 0);
    next_cycle;
    rst = 0; rvalid = 0;
    #1;
    chk("rst_mid_outs", {arvalid, rready, awvalid, wvalid, bready, data_data_ok}, 0);
    txn(tbl[0]);

    for (int i = 0; i < 40; i++) begin
      v.wr = 1'($urandom); v.size = 2'($urandom); v.addr = $urandom; v.pfn = 20'($urandom);
      v.wd = $urandom; v.rd = $urandom;
      v.ar_d = $urandom_range(0, 3); v.aw_d = $urandom_range(0, 3);
      v.w_d = $urandom_range(0, 3); v.rsp_d = $urandom_range(0, 3);
      txn(model(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
